set_region_counter: RTL and testbench

// Parametrised SET-region counter. It counts the grid points that satisfy a set expression over three circles A, B and C.
// It evaluates LANES points per cycle, using LANES instances of a point-vs-3-circle cell.
// It extends the 3-cell controller with configurable grid, lane count and coordinate width, plus union/triple modes and an error flag.

---
 rtl/set_region_counter_pkg.sv | 26 ++
 rtl/set_region_counter_if.sv | 19 +
 rtl/set_region_counter_map_cell.sv | 36 +++
 rtl/set_region_counter.sv | 154 +++++++++++++++
 tb/tb_set_region_counter.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/set_region_counter_pkg.sv
// Shared encodings and width helper for the SET region counter.
package set_pkg;

    // Set expressions over circles A, B and C; 110/111 are reserved.
    typedef enum logic [2:0] {
        MODE_A    = 3'b000,
        MODE_AND  = 3'b001,
        MODE_XOR  = 3'b010,
        MODE_TWO  = 3'b011,
        MODE_ANY  = 3'b100,
        MODE_ALL3 = 3'b101
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // Counter width able to hold every point of the grid (0..GRID_W^2).
    function automatic int cnt_width(input int grid_w);
        return $clog2(grid_w * grid_w + 1);
    endfunction

endpackage

// File: rtl/set_region_counter_if.sv
// Operand/result bundle between the SET top-level I/O and the counter.
interface set_region_counter_if #(
    parameter int COORD_W = 4,
    parameter int CNT_W   = 7
);
    logic                 en;
    logic [6*COORD_W-1:0] central;
    logic [3*COORD_W-1:0] radius;
    logic [2:0]           mode;
    logic [CNT_W-1:0]     candidate;
    logic                 busy;
    logic                 valid;
    logic                 err;

    modport master (output en, central, radius, mode,
                    input  candidate, busy, valid, err);
    modport slave  (input  en, central, radius, mode,
                    output candidate, busy, valid, err);
endinterface

// File: rtl/set_region_counter_map_cell.sv
// One grid point tested against three circles; purely combinational.
module set_map_cell #(
    parameter int COORD_W = 4,
    parameter int XY_W    = 4
) (
    input  logic [XY_W-1:0]      px,
    input  logic [XY_W-1:0]      py,
    input  logic [6*COORD_W-1:0] central,
    input  logic [3*COORD_W-1:0] radius,
    output logic [2:0]           hit
);
    localparam int D_W   = COORD_W + 2;
    localparam int SQ_W  = 2 * COORD_W + 4;
    localparam int SUM_W = SQ_W + 1;

    // hit[0]=A, hit[1]=B, hit[2]=C; A occupies the top slices of the buses.
    for (genvar gi = 0; gi < 3; gi++) begin : g_circle
        logic [COORD_W-1:0]     kx, ky, kr;
        logic signed [D_W-1:0]  dx, dy;
        logic signed [SQ_W-1:0] dx_e, dy_e, sq_x, sq_y;
        logic [SUM_W-1:0]       dist2, r2;

        assign kx    = central[(5-2*gi)*COORD_W +: COORD_W];
        assign ky    = central[(4-2*gi)*COORD_W +: COORD_W];
        assign kr    = radius[(2-gi)*COORD_W +: COORD_W];
        assign dx    = $signed(D_W'(px)) - $signed(D_W'(kx));
        assign dy    = $signed(D_W'(py)) - $signed(D_W'(ky));
        assign dx_e  = SQ_W'(dx);
        assign dy_e  = SQ_W'(dy);
        assign sq_x  = dx_e * dx_e;
        assign sq_y  = dy_e * dy_e;
        assign dist2 = SUM_W'($unsigned(sq_x)) + SUM_W'($unsigned(sq_y));
        assign r2    = SUM_W'(kr) * SUM_W'(kr);
        assign hit[gi] = (dist2 <= r2);
    end
endmodule

// File: rtl/set_region_counter.sv
// Scans the grid LANES points per cycle and counts points satisfying the set mode.
module set_region_counter
    import set_pkg::*;
#(
    parameter int GRID_W  = 8,
    parameter int LANES   = 4,
    parameter int COORD_W = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    set_region_counter_if.slave  bus
);
    localparam int N     = GRID_W * GRID_W;
    localparam int CNT_W = cnt_width(GRID_W);
    localparam int P_W   = $clog2(N);
    localparam int LOG_G = $clog2(GRID_W);
    localparam int XY_W  = LOG_G + 1;
    localparam int PC_W  = $clog2(LANES + 1);

    function automatic logic mode_pred(input logic [2:0] m, input logic [2:0] h);
        case (mode_e'(m))
            MODE_A:    return h[0];
            MODE_AND:  return h[0] & h[1];
            MODE_XOR:  return h[0] ^ h[1];
            MODE_TWO:  return (h == 3'b011) || (h == 3'b101) || (h == 3'b110);
            MODE_ANY:  return |h;
            MODE_ALL3: return &h;
            default:   return 1'b0;
        endcase
    endfunction

    function automatic logic [PC_W-1:0] popcount(input logic [LANES-1:0] b);
        logic [PC_W-1:0] c;
        c = '0;
        for (int i = 0; i < LANES; i++) c = c + PC_W'(b[i]);
        return c;
    endfunction

    state_e               state_q, state_d;
    logic [P_W-1:0]       p_q, p_d;
    logic [CNT_W-1:0]     acc_q, acc_d;
    logic [LANES-1:0]     s1_q, s1_d;
    logic                 s1_vld_q, s1_vld_d;
    logic [6*COORD_W-1:0] cen_q, cen_d;
    logic [3*COORD_W-1:0] rad_q, rad_d;
    logic [2:0]           mode_q, mode_d;
    logic                 err_q, err_d;
    logic [LANES-1:0]     lane_bits;

    // Lane gi evaluates raster point p+gi.
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        logic [P_W-1:0]  pt;
        logic [XY_W-1:0] px, py;
        logic [2:0]      hit;

        assign pt = p_q + P_W'(gi);
        assign px = XY_W'(pt[LOG_G-1:0]) + XY_W'(1);
        assign py = XY_W'(pt[P_W-1:LOG_G]) + XY_W'(1);

        set_map_cell #(.COORD_W(COORD_W), .XY_W(XY_W)) u_cell (
            .px      (px),
            .py      (py),
            .central (cen_q),
            .radius  (rad_q),
            .hit     (hit)
        );
        assign lane_bits[gi] = mode_pred(mode_q, hit);
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Next state; a start pulse restarts the scan from any state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_SCAN:  if (p_q == P_W'(N - LANES)) state_d = ST_DRAIN;
            ST_DRAIN: state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = state_q;
        endcase
        if (bus.en) state_d = ST_SCAN;
    end

    // Datapath registers: operands, scan index, stage-1 bits, accumulator.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p_q      <= '0;
            acc_q    <= '0;
            s1_q     <= '0;
            s1_vld_q <= 1'b0;
            cen_q    <= '0;
            rad_q    <= '0;
            mode_q   <= '0;
            err_q    <= 1'b0;
        end else begin
            p_q      <= p_d;
            acc_q    <= acc_d;
            s1_q     <= s1_d;
            s1_vld_q <= s1_vld_d;
            cen_q    <= cen_d;
            rad_q    <= rad_d;
            mode_q   <= mode_d;
            err_q    <= err_d;
        end
    end

    // Two-stage scan: register lane bits, then add the previous group's popcount.
    always_comb begin
        p_d      = p_q;
        acc_d    = acc_q;
        s1_d     = s1_q;
        s1_vld_d = s1_vld_q;
        cen_d    = cen_q;
        rad_d    = rad_q;
        mode_d   = mode_q;
        err_d    = err_q;
        case (state_q)
            ST_SCAN: begin
                s1_d     = lane_bits;
                s1_vld_d = 1'b1;
                p_d      = p_q + P_W'(LANES);
                if (s1_vld_q) acc_d = acc_q + CNT_W'(popcount(s1_q));
            end
            ST_DRAIN: begin
                if (s1_vld_q) acc_d = acc_q + CNT_W'(popcount(s1_q));
                s1_vld_d = 1'b0;
                err_d    = mode_q[2] & mode_q[1];
            end
            default: ;
        endcase
        if (bus.en) begin
            cen_d    = bus.central;
            rad_d    = bus.radius;
            mode_d   = bus.mode;
            acc_d    = '0;
            p_d      = '0;
            s1_d     = '0;
            s1_vld_d = 1'b0;
            err_d    = 1'b0;
        end
    end

    // Outputs decoded from the state register; the count is the accumulator itself.
    always_comb begin
        bus.busy      = (state_q == ST_SCAN) || (state_q == ST_DRAIN);
        bus.valid     = (state_q == ST_DONE);
        bus.candidate = acc_q;
        bus.err       = err_q;
    end
endmodule

// File: tb/tb_set_region_counter.sv
// Scoreboard bench for set_region_counter with the default 8x8 grid, 4 lanes.
module tb_set_region_counter;
    localparam int LAT = 18;

    typedef struct {
        int cnt;
        int err;
        int due;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   err_cnt = 0;
    int   chk_cnt = 0;
    exp_t sb[$];

    set_region_counter_if #(.COORD_W(4), .CNT_W(7)) bus ();

    set_region_counter #(.GRID_W(8), .LANES(4), .COORD_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input int got, input int exp);
        chk_cnt++;
        if (got != exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic bit in_circle(input int x, input int y, input int kx, input int ky, input int kr);
        return ((x - kx) * (x - kx) + (y - ky) * (y - ky)) <= kr * kr;
    endfunction

    function automatic int model(input logic [23:0] c, input logic [11:0] r, input logic [2:0] m);
        int cnt = 0;
        for (int y = 1; y <= 8; y++) begin
            for (int x = 1; x <= 8; x++) begin
                bit a, b, k;
                bit hit;
                int n;
                a = in_circle(x, y, int'(c[23:20]), int'(c[19:16]), int'(r[11:8]));
                b = in_circle(x, y, int'(c[15:12]), int'(c[11:8]),  int'(r[7:4]));
                k = in_circle(x, y, int'(c[7:4]),   int'(c[3:0]),   int'(r[3:0]));
                n = int'(a) + int'(b) + int'(k);
                case (m)
                    3'd0:    hit = a;
                    3'd1:    hit = a && b;
                    3'd2:    hit = a != b;
                    3'd3:    hit = (n == 2);
                    3'd4:    hit = (n >= 1);
                    3'd5:    hit = (n == 3);
                    default: hit = 1'b0;
                endcase
                if (hit) cnt++;
            end
        end
        return cnt;
    endfunction

    // Called at a falling edge; en is sampled by the next rising edge.
    task automatic start_op(input logic [23:0] c, input logic [11:0] r, input logic [2:0] m);
        exp_t e;
        bus.central = c;
        bus.radius  = r;
        bus.mode    = m;
        bus.en      = 1'b1;
        e.cnt = model(c, r, m);
        e.err = (m >= 3'd6) ? 1 : 0;
        e.due = cyc + LAT;
        sb.push_back(e);
        @(negedge clk);
        bus.en = 1'b0;
    endtask

    task automatic wait_empty();
        int n = 0;
        while (sb.size() != 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        check("timeout", sb.size(), 0);
        @(negedge clk);
    endtask

    // Result monitor: one line per completed transaction.
    always @(negedge clk) begin
        if (!rst && bus.valid) begin
            if (sb.size() == 0) begin
                check("unexpected_valid", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                $display("txn: cycle=%0d candidate=%0d err=%0d (expect %0d/%0d)",
                         cyc, bus.candidate, bus.err, e.cnt, e.err);
                check("candidate", int'(bus.candidate), e.cnt);
                check("err", int'(bus.err), e.err);
                check("latency", cyc, e.due);
            end
        end
    end

    initial begin
        bus.en = 1'b0;
        bus.central = '0;
        bus.radius = '0;
        bus.mode = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", int'(bus.busy), 0);
        check("rst_valid", int'(bus.valid), 0);
        check("rst_cand", int'(bus.candidate), 0);
        check("rst_err", int'(bus.err), 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // A=(4,4) r=2, with busy/valid timing per cycle.
        start_op({4'd4, 4'd4, 4'd0, 4'd0, 4'd0, 4'd0}, {4'd2, 4'd0, 4'd0}, 3'd0);
        for (int j = 1; j <= LAT; j++) begin
            check($sformatf("busy_c%0d", j), int'(bus.busy), (j <= 17) ? 1 : 0);
            check($sformatf("valid_c%0d", j), int'(bus.valid), (j == LAT) ? 1 : 0);
            if (j < LAT) @(negedge clk);
        end
        repeat (3) @(negedge clk);
        check("hold_cand", int'(bus.candidate), 13);
        check("hold_valid", int'(bus.valid), 0);
        check("sb_empty", sb.size(), 0);

        // Overlapping circles under each mode.
        for (int k = 0; k < 4; k++) begin
            logic [2:0] mtab [4] = '{3'd1, 3'd2, 3'd4, 3'd3};
            start_op({4'd2, 4'd2, 4'd3, 4'd2, 4'd8, 4'd8}, {4'd1, 4'd1, 4'd0}, mtab[k]);
            wait_empty();
        end

        start_op({4'd4, 4'd4, 4'd4, 4'd4, 4'd4, 4'd4}, {4'd2, 4'd2, 4'd2}, 3'd5);
        wait_empty();
        start_op({4'd4, 4'd4, 4'd0, 4'd0, 4'd0, 4'd0}, {4'd15, 4'd0, 4'd0}, 3'd0);
        wait_empty();

        // Reserved mode, then a normal op clears err.
        start_op({4'd4, 4'd4, 4'd0, 4'd0, 4'd0, 4'd0}, {4'd15, 4'd0, 4'd0}, 3'd6);
        wait_empty();
        check("err_sticky", int'(bus.err), 1);
        start_op({4'd4, 4'd4, 4'd0, 4'd0, 4'd0, 4'd0}, {4'd2, 4'd0, 4'd0}, 3'd0);
        check("err_cleared", int'(bus.err), 0);
        wait_empty();

        // Restart mid-scan: first result is discarded.
        start_op({4'd4, 4'd4, 4'd0, 4'd0, 4'd0, 4'd0}, {4'd15, 4'd0, 4'd0}, 3'd0);
        repeat (6) @(negedge clk);
        void'(sb.pop_back());
        start_op({4'd2, 4'd2, 4'd3, 4'd2, 4'd8, 4'd8}, {4'd1, 4'd1, 4'd0}, 3'd2);
        wait_empty();

        // Reset mid-scan aborts immediately.
        start_op({4'd4, 4'd4, 4'd0, 4'd0, 4'd0, 4'd0}, {4'd2, 4'd0, 4'd0}, 3'd0);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        #1;
        check("arst_busy", int'(bus.busy), 0);
        check("arst_valid", int'(bus.valid), 0);
        check("arst_cand", int'(bus.candidate), 0);
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        repeat (25) @(negedge clk);
        check("post_rst_busy", int'(bus.busy), 0);
        start_op({4'd2, 4'd2, 4'd3, 4'd2, 4'd8, 4'd8}, {4'd1, 4'd1, 4'd0}, 3'd4);
        wait_empty();

        // Random operands and modes.
        for (int k = 0; k < 8; k++) begin
            start_op(24'($urandom), 12'($urandom), 3'($urandom_range(0, 7)));
            wait_empty();
        end

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end
endmodule
